ebus_timer: RTL and testbench

- Memory-mapped 16-bit down-counter peripheral that responds to bus cycles driven by the hd6309 CPU core.
- Runs on a fast system clock and oversamples the CPU's E/Q bus clocks.
- Decodes a 4-byte register window, services CPU reads and writes, and drives nIRQ back to the CPU.
- Counter ticks once per bus cycle (each E falling edge).

---
 rtl/ebus_timer_if.sv | 22 ++
 rtl/ebus_timer.sv | 217 +++++++++++++++++++++
 tb/tb_ebus_timer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ebus_timer_if.sv
// Bus interface between the hd6309 CPU side and the timer peripheral.
// With EBUS_TIMER_FIRQ_EN defined, the interface also carries nFIRQ.
interface ebus_timer_if;
  logic [15:0] ADDR;
  logic [7:0]  DIN;
  logic [7:0]  DOUT;
  logic        DOE;
  logic        RnW;
  logic        E;
  logic        Q;
  logic        BA;
  logic        nIRQ;
`ifdef EBUS_TIMER_FIRQ_EN
  logic        nFIRQ;

  modport master (output ADDR, DIN, RnW, E, Q, BA, input DOUT, DOE, nIRQ, nFIRQ);
  modport slave  (input ADDR, DIN, RnW, E, Q, BA, output DOUT, DOE, nIRQ, nFIRQ);
`else
  modport master (output ADDR, DIN, RnW, E, Q, BA, input DOUT, DOE, nIRQ);
  modport slave  (input ADDR, DIN, RnW, E, Q, BA, output DOUT, DOE, nIRQ);
`endif
endinterface

// File: rtl/ebus_timer.sv
// ebus_timer: memory-mapped 16-bit down-counter on the hd6309 E/Q bus.
// E and Q are oversampled on CLK; the counter ticks on every E falling edge.
// Optional macro EBUS_TIMER_FIRQ_EN adds nFIRQ and the CTRL.FSEL routing bit.
//
// state  | meaning
// S_IDLE | waiting for Q rising edge
// S_ADDR | address/RnW latched; one CLK to take the COUNT_HI snapshot
// S_DATA | E phase; DIN captured while E high, write commits on E fall
module ebus_timer #(
  parameter logic [15:0] BASE_ADDR   = 16'hFF40,
  parameter int          SYNC_STAGES = 2
) (
  input logic         CLK,
  input logic         RESET,
  ebus_timer_if.slave bus
);
  localparam logic [13:0] BASE_HI = BASE_ADDR[15:2];

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;
  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] e_sync, q_sync;
  logic e_s, q_s, e_d, q_d, e_fall, q_rise;

  logic       sel_q, rnw_q, sel_now;
  logic [1:0] off_q, rd_off;
  logic [7:0] hold_q, rd_data;
  logic       start, commit, snap_en, load;

  logic        en_q, ie_q, auto_q, exp_q;
  logic        en_d, ie_d, auto_d, exp_d;
  logic [15:0] reload_q, reload_d, count_q, count_d;
  logic [7:0]  snap_q, snap_d;
  logic        fsel_q, fsel_d;
  logic        nirq_q;
  logic [7:0]  dout_q;
  logic        doe_q;

  assign e_s     = e_sync[SYNC_STAGES-1];
  assign q_s     = q_sync[SYNC_STAGES-1];
  assign e_fall  = ~e_s & e_d;
  assign q_rise  = q_s & ~q_d;
  assign sel_now = (bus.ADDR[15:2] == BASE_HI) & ~bus.BA;

  // Synchronize E/Q into the CLK domain and keep last values for edge detection.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      e_sync <= '0;
      q_sync <= '0;
      e_d    <= 1'b0;
      q_d    <= 1'b0;
    end else begin
      e_sync <= {e_sync[SYNC_STAGES-2:0], bus.E};
      q_sync <= {q_sync[SYNC_STAGES-2:0], bus.Q};
      e_d    <= e_s;
      q_d    <= q_s;
    end
  end

  // Bus cycle next state and the single-CLK access strobes.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    commit  = 1'b0;
    snap_en = 1'b0;
    case (state_q)
      S_IDLE: if (q_rise) begin
        state_d = S_ADDR;
        start   = 1'b1;
      end
      S_ADDR: begin
        state_d = S_DATA;
        snap_en = sel_q & rnw_q & (off_q == 2'd2);
      end
      S_DATA: if (e_fall) begin
        state_d = S_IDLE;
        commit  = sel_q & ~rnw_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register, address-phase latches and the write-data holding register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      rnw_q   <= 1'b1;
      off_q   <= 2'd0;
      hold_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      if (start) begin
        sel_q <= sel_now;
        rnw_q <= bus.RnW;
        off_q <= bus.ADDR[1:0];
      end
      if (state_q == S_DATA && e_s) hold_q <= bus.DIN;
    end
  end

  // Register writes first, then the tick; a load suppresses the tick and a tick
  // expiry overrides a same-cycle EXP clear.
  always_comb begin
    en_d     = en_q;
    ie_d     = ie_q;
    auto_d   = auto_q;
    fsel_d   = fsel_q;
    exp_d    = exp_q;
    reload_d = reload_q;
    count_d  = count_q;
    snap_d   = snap_q;
    load     = 1'b0;
    if (snap_en) snap_d = count_q[7:0];
    if (commit) begin
      case (off_q)
        2'd0: begin
          en_d   = hold_q[0];
          ie_d   = hold_q[1];
          auto_d = hold_q[2];
`ifdef EBUS_TIMER_FIRQ_EN
          fsel_d = hold_q[3];
`endif
        end
        2'd1: if (hold_q[0]) exp_d = 1'b0;
        2'd2: reload_d[15:8] = hold_q;
        default: begin
          reload_d[7:0] = hold_q;
          count_d       = {reload_q[15:8], hold_q};
          load          = 1'b1;
        end
      endcase
    end
    if (e_fall && en_q && en_d && !load) begin
      if (count_q != 16'd0) begin
        count_d = count_q - 16'd1;
      end else begin
        exp_d = 1'b1;
        if (auto_d) count_d = reload_d;
        else        en_d    = 1'b0;
      end
    end
  end

  // Timer/control registers and the registered interrupt outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      auto_q   <= 1'b0;
      fsel_q   <= 1'b0;
      exp_q    <= 1'b0;
      reload_q <= 16'h0000;
      count_q  <= 16'h0000;
      snap_q   <= 8'h00;
      nirq_q   <= 1'b1;
    end else begin
      en_q     <= en_d;
      ie_q     <= ie_d;
      auto_q   <= auto_d;
      fsel_q   <= fsel_d;
      exp_q    <= exp_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      snap_q   <= snap_d;
`ifdef EBUS_TIMER_FIRQ_EN
      nirq_q   <= ~(exp_q & ie_q & ~fsel_q);
`else
      nirq_q   <= ~(exp_q & ie_q);
`endif
    end
  end

`ifdef EBUS_TIMER_FIRQ_EN
  logic nfirq_q;

  // Fast-interrupt output, used when CTRL.FSEL routes the request here.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) nfirq_q <= 1'b1;
    else       nfirq_q <= ~(exp_q & ie_q & fsel_q);
  end

  assign bus.nFIRQ = nfirq_q;
`endif

  // Read mux; uses the live address on the Q-rise CLK, the latched offset after.
  always_comb begin
    rd_off  = (state_q == S_IDLE) ? bus.ADDR[1:0] : off_q;
    rd_data = 8'h00;
    case (rd_off)
      2'd0:    rd_data = {4'b0000, fsel_q, auto_q, ie_q, en_q};
      2'd1:    rd_data = {~nirq_q, 6'b000000, exp_q};
      2'd2:    rd_data = count_q[15:8];
      default: rd_data = snap_q;
    endcase
  end

  // Read data register and output enable for the external bus mux.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dout_q <= 8'h00;
      doe_q  <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (q_rise) begin
        doe_q <= sel_now & bus.RnW;
        if (sel_now && bus.RnW) dout_q <= rd_data;
      end
    end else if (sel_q && rnw_q) begin
      dout_q <= rd_data;
      if (state_q == S_DATA && e_fall) doe_q <= 1'b0;
    end
  end

  assign bus.DOUT = dout_q;
  assign bus.DOE  = doe_q;
  assign bus.nIRQ = nirq_q;
endmodule

// File: tb/tb_ebus_timer.sv
// Self-checking bench for ebus_timer: directed scenarios plus random bus
// traffic, compared each bus cycle against a bus-cycle-level register model.
module tb_ebus_timer;
  logic CLK = 1'b0;
  logic RESET;
  ebus_timer_if bus();

  ebus_timer dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Model state, advanced once per bus cycle.
  logic        m_en, m_ie, m_auto, m_fsel, m_exp;
  logic [15:0] m_reload, m_count;
  logic [7:0]  m_snap, m_dout;

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic m_irq();
`ifdef EBUS_TIMER_FIRQ_EN
    return m_exp & m_ie & ~m_fsel;
`else
    return m_exp & m_ie;
`endif
  endfunction

  function automatic logic [7:0] m_read(input logic [1:0] off);
    case (off)
      2'd0:    return {4'b0000, m_fsel, m_auto, m_ie, m_en};
      2'd1:    return {m_irq(), 6'b000000, m_exp};
      2'd2:    return m_count[15:8];
      default: return m_snap;
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_ie = 0; m_auto = 0; m_fsel = 0; m_exp = 0;
    m_reload = 16'h0000; m_count = 16'h0000; m_snap = 8'h00; m_dout = 8'h00;
  endtask

  // End-of-bus-cycle update: apply a selected write, then the timer tick.
  task automatic model_efall(input logic wr, input logic [1:0] off, input logic [7:0] d);
    logic tick;
    tick = m_en && !(wr && off == 2'd0 && !d[0]) && !(wr && off == 2'd3);
    if (wr) begin
      case (off)
        2'd0: begin
          m_en = d[0]; m_ie = d[1]; m_auto = d[2];
`ifdef EBUS_TIMER_FIRQ_EN
          m_fsel = d[3];
`endif
        end
        2'd1: if (d[0]) m_exp = 1'b0;
        2'd2: m_reload[15:8] = d;
        default: begin
          m_reload[7:0] = d;
          m_count = {m_reload[15:8], d};
        end
      endcase
    end
    if (tick) begin
      if (m_count != 0) m_count = m_count - 16'd1;
      else begin
        m_exp = 1'b1;
        if (m_auto) m_count = m_reload;
        else m_en = 1'b0;
      end
    end
  endtask

  // One 16-CLK bus cycle: Q high CLK 1..8, E high CLK 5..12; outputs compared at CLK 12.
  task automatic bus_cycle(input logic [15:0] a, input logic rnw, input logic ba,
                           input logic [7:0] d, input bit do_rst, output logic [7:0] rd);
    logic       sel, exp_doe;
    logic [1:0] off;
    logic [7:0] exp_rd;
    logic       exp_irq;
    sel     = (a[15:2] == 14'h3FD0) && !ba;
    off     = a[1:0];
    exp_doe = sel & rnw;
    exp_irq = m_irq();
    exp_rd  = m_read(off);
    if (exp_doe) m_dout = exp_rd;
    if (exp_doe && off == 2'd2) m_snap = m_count[7:0];
    rd = 8'h00;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      if (i == 0) begin
        bus.ADDR = a; bus.RnW = rnw; bus.BA = ba; bus.DIN = d;
      end
      bus.Q = (i >= 1 && i < 9);
      bus.E = (i >= 5 && i < 13);
      if (!do_rst) begin
        if (i == 2) chk1("doe_before_qrise", bus.DOE, 1'b0);
        if (i == 12) begin
          chk1("doe", bus.DOE, exp_doe);
          chk8("dout", bus.DOUT, m_dout);
          chk1("nirq", bus.nIRQ, ~exp_irq);
`ifdef EBUS_TIMER_FIRQ_EN
          chk1("nfirq", bus.nFIRQ, ~(m_exp & m_ie & m_fsel));
`endif
          rd = bus.DOUT;
        end
      end else begin
        if (i == 8) begin
          RESET = 1'b1;
          #1;
          chk1("rst_doe", bus.DOE, 1'b0);
          chk1("rst_nirq", bus.nIRQ, 1'b1);
        end
        if (i == 10) RESET = 1'b0;
      end
    end
    if (do_rst) model_reset();
    else model_efall(sel & !rnw, off, d);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    logic [7:0] rd;
    bus_cycle(a, 1'b0, 1'b0, d, 1'b0, rd);
  endtask

  task automatic rd_lit(input string nm, input logic [15:0] a, input logic [7:0] lit);
    logic [7:0] rd;
    chk8({nm, "_model"}, m_read(a[1:0]), lit);
    bus_cycle(a, 1'b1, 1'b0, 8'h00, 1'b0, rd);
    chk8(nm, rd, lit);
  endtask

  task automatic idle(input int n);
    logic [7:0] rd;
    for (int k = 0; k < n; k++) bus_cycle(16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, rd);
  endtask

  initial begin
    logic [7:0]  rd;
    logic [15:0] a;
    logic        rnw, ba;
    logic [7:0]  d;
    int unsigned rv;

    RESET = 1'b1;
    bus.ADDR = 16'h0000; bus.DIN = 8'h00; bus.RnW = 1'b1;
    bus.E = 1'b0; bus.Q = 1'b0; bus.BA = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    chk1("reset_doe", bus.DOE, 1'b0);
    chk1("reset_nirq", bus.nIRQ, 1'b1);
    chk8("reset_dout", bus.DOUT, 8'h00);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // One-shot: count 3, four ticks to expiry.
    wr(16'hFF42, 8'h00);
    wr(16'hFF43, 8'h03);
    wr(16'hFF40, 8'h03);
    idle(4);
    chk1("oneshot_model_exp", m_exp, 1'b1);
    rd_lit("oneshot_status", 16'hFF41, 8'h81);
    rd_lit("oneshot_ctrl", 16'hFF40, 8'h02);

    // Collision: expiry on the same E fall as an EXP clear.
    wr(16'hFF41, 8'h01);
    wr(16'hFF43, 8'h01);
    wr(16'hFF40, 8'h03);
    idle(1);
    wr(16'hFF41, 8'h01);
    rd_lit("collide_status", 16'hFF41, 8'h81);

    // Auto-reload with RELOAD=2: expiry every 3 bus cycles.
    wr(16'hFF41, 8'h01);
    wr(16'hFF42, 8'h00);
    wr(16'hFF43, 8'h02);
    wr(16'hFF40, 8'h07);
    idle(3);
    rd_lit("auto_exp1", 16'hFF41, 8'h81);
    wr(16'hFF41, 8'h01);
    rd_lit("auto_clr1", 16'hFF41, 8'h00);
    rd_lit("auto_exp2", 16'hFF41, 8'h81);
    wr(16'hFF41, 8'h01);
    rd_lit("auto_clr2", 16'hFF41, 8'h00);
    wr(16'hFF40, 8'h00);
    wr(16'hFF41, 8'h01);

    // Snapshot: COUNT=1234, one tick, then HI/LO reads.
    wr(16'hFF40, 8'h01);
    wr(16'hFF42, 8'h12);
    wr(16'hFF43, 8'h34);
    idle(1);
    rd_lit("snap_hi", 16'hFF42, 8'h12);
    rd_lit("snap_lo", 16'hFF43, 8'h33);
    wr(16'hFF40, 8'h00);

    // Decode: BA=1 and out-of-window accesses are ignored.
    bus_cycle(16'hFF40, 1'b0, 1'b1, 8'h07, 1'b0, rd);
    rd_lit("decode_ba_wr", 16'hFF40, 8'h00);
    bus_cycle(16'hFF44, 1'b1, 1'b0, 8'h00, 1'b0, rd);
    bus_cycle(16'hFF41, 1'b1, 1'b1, 8'h00, 1'b0, rd);
    wr(16'hFF44, 8'h07);
    rd_lit("decode_ff44_wr", 16'hFF40, 8'h00);

    // Reset mid-DATA during a read of a running timer.
    wr(16'hFF42, 8'hAB);
    wr(16'hFF43, 8'h05);
    wr(16'hFF40, 8'h07);
    bus_cycle(16'hFF40, 1'b1, 1'b0, 8'h00, 1'b1, rd);
    rd_lit("post_rst_ctrl", 16'hFF40, 8'h00);
    rd_lit("post_rst_status", 16'hFF41, 8'h00);
    rd_lit("post_rst_hi", 16'hFF42, 8'h00);
    rd_lit("post_rst_lo", 16'hFF43, 8'h00);

    // Random traffic, biased toward the register window and short counts.
    for (int n = 0; n < 400; n++) begin
      rv = $urandom;
      if ($urandom_range(0, 99) < 75) a = {14'h3FD0, rv[1:0]};
      else if ($urandom_range(0, 1) == 0) a = 16'hFF44 + {14'h0000, rv[3:2]};
      else a = rv[31:16];
      rnw = ($urandom_range(0, 1) == 1);
      ba  = ($urandom_range(0, 9) == 0);
      rv  = $urandom;
      d   = rv[7:0];
      if (a[1:0] == 2'd2 && $urandom_range(0, 3) != 0) d = 8'h00;
      if (a[1:0] == 2'd3) d = d & 8'h07;
      if (a[1:0] == 2'd0) d[0] = ($urandom_range(0, 3) != 0);
      if (a[1:0] == 2'd1 && $urandom_range(0, 2) == 0) d[0] = 1'b0;
      bus_cycle(a, rnw, ba, d, 1'b0, rd);
    end

    repeat (4) @(negedge CLK);
    chk1("final_nirq", bus.nIRQ, ~m_irq());
    chk1("final_doe", bus.DOE, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
